// File: rtl/zx81_tape_pkg.sv
// zx81_tape_pkg: shared types and constants for the ZX81 tape player.
// Holds the waveform state enum, the controller state enum, pulse counts
// and default timing. Optional pause support: ZX81_TAPE_PAUSE_EN.
package zx81_tape_pkg;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      LOAD,
      PULSE_HI,
      PULSE_LO,
      GAP,
      PAUSE
   } tape_state_t;

   typedef enum logic [2:0] {
      C_IDLE,
      C_FETCH,
      C_LOAD,
      C_RUN,
      C_PAUSE
   } ctl_state_t;

   localparam int ZERO_PULSES    = 4;
   localparam int ONE_PULSES     = 9;
   localparam int DEF_ADDR_W     = 16;
   localparam int DEF_HALF_TICKS = 75;
   localparam int DEF_GAP_TICKS  = 650;
   localparam int DEF_RD_LAT     = 1;
   localparam int TCNT_W         = 10;
   localparam int PCNT_W         = 4;

   function automatic logic [PCNT_W-1:0] pulses_for(input logic b);
      return b ? PCNT_W'(ONE_PULSES) : PCNT_W'(ZERO_PULSES);
   endfunction

endpackage

// File: rtl/zx81_tape_bit_shaper.sv
// zx81_tape_bit_shaper: turns one bit into ZX81 pulses plus trailing gap.
// Ports: i_clk, i_reset_n (sync, active low), i_tick (count enable),
//   i_start/i_bit (begin a bit), i_abort (drop to idle), i_hold (freeze),
//   o_pulse (waveform), o_done (strobe on the last gap tick).
module zx81_tape_bit_shaper
   import zx81_tape_pkg::*;
#(
   parameter int HALF_TICKS = DEF_HALF_TICKS,
   parameter int GAP_TICKS  = DEF_GAP_TICKS
) (
   input  logic i_clk,
   input  logic i_reset_n,
   input  logic i_tick,
   input  logic i_start,
   input  logic i_bit,
   input  logic i_abort,
   input  logic i_hold,
   output logic o_pulse,
   output logic o_done
);

   tape_state_t       r_phase, w_phase_nx;
   logic [TCNT_W-1:0] r_tcnt, w_tcnt_nx;
   logic [PCNT_W-1:0] r_pcnt, w_pcnt_nx;
   logic [PCNT_W-1:0] w_pcnt_inc;
   logic              r_bit, w_bit_nx;
   logic              w_step;
   logic              w_half_end;
   logic              w_gap_end;

   assign w_step     = i_tick & ~i_hold;
   assign w_half_end = (r_tcnt == TCNT_W'(HALF_TICKS - 1));
   assign w_gap_end  = (r_tcnt == TCNT_W'(GAP_TICKS - 1));
   assign w_pcnt_inc = r_pcnt + PCNT_W'(1);

   // Kept independent of i_start: the parent answers done with start.
   assign o_done  = (r_phase == GAP) & w_step & w_gap_end;
   assign o_pulse = (r_phase == PULSE_HI);

   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         r_phase <= IDLE;
         r_tcnt  <= '0;
         r_pcnt  <= '0;
         r_bit   <= 1'b0;
      end else begin
         r_phase <= w_phase_nx;
         r_tcnt  <= w_tcnt_nx;
         r_pcnt  <= w_pcnt_nx;
         r_bit   <= w_bit_nx;
      end
   end

   always_comb begin
      w_phase_nx = r_phase;
      w_tcnt_nx  = r_tcnt;
      w_pcnt_nx  = r_pcnt;
      w_bit_nx   = r_bit;
      if (i_abort) begin
         w_phase_nx = IDLE;
         w_tcnt_nx  = '0;
         w_pcnt_nx  = '0;
      end else if (i_start) begin
         w_phase_nx = PULSE_HI;
         w_tcnt_nx  = '0;
         w_pcnt_nx  = '0;
         w_bit_nx   = i_bit;
      end else if (w_step) begin
         unique case (r_phase)
            PULSE_HI: begin
               if (w_half_end) begin
                  w_phase_nx = PULSE_LO;
                  w_tcnt_nx  = '0;
               end else begin
                  w_tcnt_nx = r_tcnt + TCNT_W'(1);
               end
            end
            PULSE_LO: begin
               if (w_half_end) begin
                  w_tcnt_nx = '0;
                  w_pcnt_nx = w_pcnt_inc;
                  if (w_pcnt_inc == pulses_for(r_bit))
                     w_phase_nx = GAP;
                  else
                     w_phase_nx = PULSE_HI;
               end else begin
                  w_tcnt_nx = r_tcnt + TCNT_W'(1);
               end
            end
            GAP: begin
               if (w_gap_end) begin
                  w_phase_nx = IDLE;
                  w_tcnt_nx  = '0;
               end else begin
                  w_tcnt_nx = r_tcnt + TCNT_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/zx81_tape_sequencer.sv
// zx81_tape_sequencer: plays a .P image from the tape buffer as ZX81 pulses.
// Ports: i_clk, i_reset_n (sync, active low), i_tick, play/stop/eject buttons,
//   i_len_wr/i_len (image length), o_rd_addr/o_rd_en/i_rd_data (buffer),
//   o_tape_out, o_play_on, o_tape_loaded. Optional: ZX81_TAPE_PAUSE_EN.
module zx81_tape_sequencer
   import zx81_tape_pkg::*;
#(
   parameter int ADDR_W     = DEF_ADDR_W,
   parameter int HALF_TICKS = DEF_HALF_TICKS,
   parameter int GAP_TICKS  = DEF_GAP_TICKS,
   parameter int RD_LAT     = DEF_RD_LAT
) (
   input  logic              i_clk,
   input  logic              i_reset_n,
   input  logic              i_tick,
   input  logic              i_play_btn,
   input  logic              i_stop_btn,
   input  logic              i_eject_btn,
   input  logic              i_len_wr,
   input  logic [ADDR_W-1:0] i_len,
   output logic [ADDR_W-1:0] o_rd_addr,
   output logic              o_rd_en,
   input  logic [7:0]        i_rd_data,
   output logic              o_tape_out,
   output logic              o_play_on,
   output logic              o_tape_loaded
);

   ctl_state_t        r_state, w_state_nx;
   logic [ADDR_W-1:0] r_pos, w_pos_nx;
   logic [ADDR_W-1:0] r_len;
   logic [ADDR_W-1:0] w_pos_inc;
   logic [7:0]        r_byte, w_byte_nx;
   logic [2:0]        r_bit_idx, w_bit_idx_nx;
   logic [1:0]        r_lat, w_lat_nx;
   logic [2:0]        r_btn_s, r_btn_d;
   logic [2:0]        w_edge;
   logic              w_eject, w_stop, w_play;
   logic              w_start, w_sbit, w_abort, w_hold;
   logic              w_done, w_pulse;

   // Bit order in the vectors: {eject, stop, play}.
   assign w_edge  = r_btn_s & ~r_btn_d;
   assign w_eject = w_edge[2] | i_len_wr;
   assign w_stop  = w_edge[1] & ~w_eject;
   assign w_play  = w_edge[0] & ~w_edge[1] & ~w_eject;

   assign w_pos_inc     = r_pos + ADDR_W'(1);
   assign o_rd_addr     = r_pos;
   assign o_play_on     = (r_state != C_IDLE);
   assign o_tape_out    = w_pulse;
   assign o_tape_loaded = (r_len != '0);

   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         r_state   <= C_IDLE;
         r_pos     <= '0;
         r_len     <= '0;
         r_byte    <= '0;
         r_bit_idx <= '0;
         r_lat     <= '0;
         r_btn_s   <= '0;
         r_btn_d   <= '0;
      end else begin
         r_state   <= w_state_nx;
         r_pos     <= w_pos_nx;
         r_byte    <= w_byte_nx;
         r_bit_idx <= w_bit_idx_nx;
         r_lat     <= w_lat_nx;
         r_btn_s   <= {i_eject_btn, i_stop_btn, i_play_btn};
         r_btn_d   <= r_btn_s;
         if (i_len_wr)
            r_len <= i_len;
         else if (w_edge[2])
            r_len <= '0;
      end
   end

   always_comb begin
      w_state_nx   = r_state;
      w_pos_nx     = r_pos;
      w_byte_nx    = r_byte;
      w_bit_idx_nx = r_bit_idx;
      w_lat_nx     = r_lat;
      w_start      = 1'b0;
      w_sbit       = 1'b0;
      w_abort      = 1'b0;
      w_hold       = 1'b0;
      o_rd_en      = 1'b0;
      if (w_eject) begin
         w_state_nx = C_IDLE;
         w_pos_nx   = '0;
         w_abort    = 1'b1;
      end else if (w_stop) begin
         // Position is kept so the next play refetches the current byte.
         w_state_nx = C_IDLE;
         w_abort    = 1'b1;
      end else begin
         unique case (r_state)
            C_IDLE: begin
               if (w_play && r_len != '0 && r_pos < r_len) begin
                  w_state_nx = C_FETCH;
                  w_lat_nx   = '0;
               end
            end
            C_FETCH: begin
               o_rd_en = (r_lat == 2'd0);
               if (r_lat == 2'(RD_LAT - 1))
                  w_state_nx = C_LOAD;
               else
                  w_lat_nx = r_lat + 2'd1;
            end
            C_LOAD: begin
               w_byte_nx    = i_rd_data;
               w_bit_idx_nx = 3'd7;
               w_start      = 1'b1;
               w_sbit       = i_rd_data[7];
               w_state_nx   = C_RUN;
            end
            C_RUN: begin
`ifdef ZX81_TAPE_PAUSE_EN
               // Freeze in the edge cycle too, so no tick is lost.
               if (w_play) begin
                  w_state_nx = C_PAUSE;
                  w_hold     = 1'b1;
               end else
`endif
               if (w_done) begin
                  if (r_bit_idx != 3'd0) begin
                     w_bit_idx_nx = r_bit_idx - 3'd1;
                     w_start      = 1'b1;
                     w_sbit       = r_byte[r_bit_idx - 3'd1];
                  end else if (w_pos_inc == r_len) begin
                     w_pos_nx   = '0;
                     w_state_nx = C_IDLE;
                  end else begin
                     w_pos_nx   = w_pos_inc;
                     w_lat_nx   = '0;
                     w_state_nx = C_FETCH;
                  end
               end
            end
`ifdef ZX81_TAPE_PAUSE_EN
            C_PAUSE: begin
               w_hold = 1'b1;
               if (w_play)
                  w_state_nx = C_RUN;
            end
`endif
            default: w_state_nx = C_IDLE;
         endcase
      end
   end

   zx81_tape_bit_shaper #(
      .HALF_TICKS(HALF_TICKS),
      .GAP_TICKS (GAP_TICKS)
   ) u_shaper (
      .i_clk    (i_clk),
      .i_reset_n(i_reset_n),
      .i_tick   (i_tick),
      .i_start  (w_start),
      .i_bit    (w_sbit),
      .i_abort  (w_abort),
      .i_hold   (w_hold),
      .o_pulse  (w_pulse),
      .o_done   (w_done)
   );

endmodule
